// File: rtl/sub4_serial.sv
// rtl/sub4_serial.sv - bit-serial subtractor Diff = A - B - Bin, LSB first, start/done handshake
// One bit per clock; Diff/Bout update only on the final bit so no partial result is visible.
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operands shift right so bit i is always at position 0; result fills from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_br  <= Bin;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            Diff <= {w_d, r_res[WIDTH-1:1]};
            Bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub4_serial.sv
// tb/tb_sub4_serial.sv - directed and exhaustive self-checking bench for sub4_serial
module tb_sub4_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [3:0] Diff;
  logic       Bout;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int done_pulses = 0;
  logic [3:0] exp_diff_prev = 4'd0;
  logic       exp_bout_prev = 1'b0;

  sub4_serial #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .Diff (Diff),
    .Bout (Bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation from acceptance through the DONE->IDLE edge, checking every cycle.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] a_after, input bit keep_start,
                        input logic [3:0] ed, input logic eb);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) begin
      start = 1'b0;
      B = ~b;
      Bin = ~bin;
    end
    A = a_after;
    check("busy_e0", busy, 1);
    check("done_e0", done, 0);
    check("diff_hold_e0", Diff, exp_diff_prev);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      check("busy_shift", busy, 1);
      check("done_shift", done, 0);
      check("diff_hold_shift", Diff, exp_diff_prev);
      check("bout_hold_shift", Bout, exp_bout_prev);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 0);
    check("diff", Diff, ed);
    check("bout", Bout, eb);
    exp_diff_prev = ed;
    exp_bout_prev = eb;
    @(posedge clk); #1;
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("diff_after", Diff, ed);
  endtask

  initial begin
    int pulses_snap;
    rst_n = 1'b0; start = 1'b0; A = 4'd0; B = 4'd0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_diff", Diff, 0);
    check("rst_bout", Bout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd5, 4'd3, 1'b0, 4'd10, 1'b0, 4'd2, 1'b0);
    run_op(4'd0, 4'd1, 1'b0, 4'd15, 1'b0, 4'd15, 1'b1);
    run_op(4'd15, 4'd15, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1);
    run_op(4'd8, 4'd7, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0);

    // start held high; A changes mid-operation, then the next op takes the new A.
    run_op(4'd9, 4'd4, 1'b0, 4'd1, 1'b1, 4'd5, 1'b0);
    run_op(4'd1, 4'd4, 1'b0, 4'd1, 1'b0, 4'd13, 1'b1);

    // Asynchronous reset after two processed bits of 12-3.
    A = 4'd12; B = 4'd3; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    pulses_snap = done_pulses;
    #3 rst_n = 1'b0;
    #1;
    check("arst_diff", Diff, 0);
    check("arst_bout", Bout, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_done", done_pulses, pulses_snap);
    check("arst_idle", busy, 0);
    exp_diff_prev = 4'd0;
    exp_bout_prev = 1'b0;
    run_op(4'd12, 4'd3, 1'b0, 4'd0, 1'b0, 4'd9, 1'b0);

    pulses_snap = done_pulses;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          int d;
          d = (a - b - c) & 15;
          run_op(4'(a), 4'(b), 1'(c), 4'(~a), 1'b0, 4'(d), (a < b + c) ? 1'b1 : 1'b0);
        end
    check("exh_pulses", done_pulses - pulses_snap, 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
